// File: rtl/mac_operand_server_if.sv
// Load-stream and engine read-port bundle for mac_operand_server.
// slave = the operand server, master = host/DMA plus MAC engine side.
interface mac_operand_server_if #(
    parameter int M  = 3,
    parameter int K  = 5,
    parameter int N  = 5,
    parameter int DW = 32
);
    logic                 load_start;
    logic                 load_valid;
    logic [DW-1:0]        load_data;
    logic                 load_ready;
    logic                 load_done;
    logic                 operands_ready;
    logic [$clog2(M)-1:0] row_addr_a;
    logic [$clog2(K)-1:0] col_addr_a;
    logic                 matrix_a_re;
    logic [$clog2(K)-1:0] row_addr_b;
    logic [$clog2(N)-1:0] col_addr_b;
    logic                 matrix_b_re;
    logic                 mac_done;
    logic [DW-1:0]        data_in_a;
    logic [DW-1:0]        data_in_b;
    logic                 data_valid_a;
    logic                 data_valid_b;
    logic                 range_err;

    modport slave (
        input  load_start, load_valid, load_data,
        input  row_addr_a, col_addr_a, matrix_a_re,
        input  row_addr_b, col_addr_b, matrix_b_re,
        input  mac_done,
        output load_ready, load_done, operands_ready,
        output data_in_a, data_in_b, data_valid_a, data_valid_b, range_err
    );

    modport master (
        output load_start, load_valid, load_data,
        output row_addr_a, col_addr_a, matrix_a_re,
        output row_addr_b, col_addr_b, matrix_b_re,
        output mac_done,
        input  load_ready, load_done, operands_ready,
        input  data_in_a, data_in_b, data_valid_a, data_valid_b, range_err
    );
endinterface

// File: rtl/mac_operand_server.sv
// Operand memory for mac_stop: streams in A (MxK) then B (KxN) row-major, then serves
// registered 1-cycle reads until mac_done. Optional feature macro: OPERAND_RANGE_CHECK_EN.
module mac_operand_server #(
    parameter int M                      = 3,
    parameter int K                      = 5,
    parameter int N                      = 5,
    parameter int DATA_WIDTH_INIT_MATRIX = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    mac_operand_server_if.slave   bus
);
    localparam int DW      = DATA_WIDTH_INIT_MATRIX;
    localparam int A_WORDS = M * K;
    localparam int B_WORDS = K * N;
    localparam int A_IDX_W = $clog2(A_WORDS);
    localparam int B_IDX_W = $clog2(B_WORDS);
    localparam int RA_W    = $clog2(M);
    localparam int CA_W    = $clog2(K);
    localparam int RB_W    = $clog2(K);
    localparam int CB_W    = $clog2(N);
    localparam int LROW_W  = $clog2((M > K) ? M : K);
    localparam int LCOL_W  = $clog2((K > N) ? K : N);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_SERVE  = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic              load_ready_int;
    logic              operands_ready_int;
    logic              load_accept;
    logic              start_accept;
    logic              last_col;
    logic              last_row;
    logic              a_done;
    logic              b_done;
    logic              cnt_clear;
    logic [LROW_W-1:0] load_row_reg;
    logic [LCOL_W-1:0] load_col_reg;
    logic              load_done_reg;

    logic [DW-1:0]      mem_a [A_WORDS];
    logic [DW-1:0]      mem_b [B_WORDS];
    logic [A_IDX_W-1:0] a_wr_idx;
    logic [B_IDX_W-1:0] b_wr_idx;
    logic [A_IDX_W-1:0] a_rd_idx;
    logic [B_IDX_W-1:0] b_rd_idx;
    logic               a_wr_en;
    logic               b_wr_en;
    logic               a_rd_en;
    logic               b_rd_en;
    logic               a_oor;
    logic               b_oor;
    logic [DW-1:0]      data_a_reg;
    logic [DW-1:0]      data_b_reg;
    logic               valid_a_reg;
    logic               valid_b_reg;

    assign load_accept  = bus.load_valid & load_ready_int;
    assign start_accept = (state_reg == ST_IDLE) & bus.load_start;

    // The load counters track position within whichever matrix is currently streaming.
    assign last_col = (state_reg == ST_LOAD_A) ? (load_col_reg == LCOL_W'(K - 1))
                                               : (load_col_reg == LCOL_W'(N - 1));
    assign last_row = (state_reg == ST_LOAD_A) ? (load_row_reg == LROW_W'(M - 1))
                                               : (load_row_reg == LROW_W'(K - 1));
    assign a_done    = load_accept & (state_reg == ST_LOAD_A) & last_row & last_col;
    assign b_done    = load_accept & (state_reg == ST_LOAD_B) & last_row & last_col;
    assign cnt_clear = start_accept | a_done | b_done;

    // FSM: state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (bus.load_start) state_next = ST_LOAD_A;
            ST_LOAD_A: if (a_done)         state_next = ST_LOAD_B;
            ST_LOAD_B: if (b_done)         state_next = ST_SERVE;
            ST_SERVE:  if (bus.mac_done)   state_next = ST_IDLE;
            default:                       state_next = ST_IDLE;
        endcase
    end

    // FSM: Moore outputs
    always_comb begin
        load_ready_int     = 1'b0;
        operands_ready_int = 1'b0;
        case (state_reg)
            ST_LOAD_A, ST_LOAD_B: load_ready_int     = 1'b1;
            ST_SERVE:             operands_ready_int = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            load_row_reg  <= '0;
            load_col_reg  <= '0;
            load_done_reg <= 1'b0;
        end else begin
            load_done_reg <= b_done;
            if (cnt_clear) begin
                load_row_reg <= '0;
                load_col_reg <= '0;
            end else if (load_accept) begin
                if (last_col) begin
                    load_col_reg <= '0;
                    load_row_reg <= load_row_reg + 1'b1;
                end else begin
                    load_col_reg <= load_col_reg + 1'b1;
                end
            end
        end
    end

    assign a_wr_en  = load_accept & (state_reg == ST_LOAD_A);
    assign b_wr_en  = load_accept & (state_reg == ST_LOAD_B);
    assign a_wr_idx = A_IDX_W'(load_row_reg) * A_IDX_W'(K) + A_IDX_W'(load_col_reg);
    assign b_wr_idx = B_IDX_W'(load_row_reg) * B_IDX_W'(N) + B_IDX_W'(load_col_reg);

    // Storage has no reset so the arrays map onto block RAM.
    always_ff @(posedge clk) begin
        if (a_wr_en) begin
            mem_a[a_wr_idx] <= bus.load_data;
        end
        if (b_wr_en) begin
            mem_b[b_wr_idx] <= bus.load_data;
        end
    end

    assign a_rd_en  = (state_reg == ST_SERVE) & bus.matrix_a_re;
    assign b_rd_en  = (state_reg == ST_SERVE) & bus.matrix_b_re;
    assign a_rd_idx = A_IDX_W'(bus.row_addr_a) * A_IDX_W'(K) + A_IDX_W'(bus.col_addr_a);
    assign b_rd_idx = B_IDX_W'(bus.row_addr_b) * B_IDX_W'(N) + B_IDX_W'(bus.col_addr_b);

`ifdef OPERAND_RANGE_CHECK_EN
    logic range_err_reg;

    // Widen by one bit so a dimension that is an exact power of two still compares correctly.
    assign a_oor = ({1'b0, bus.row_addr_a} >= (RA_W + 1)'(M)) |
                   ({1'b0, bus.col_addr_a} >= (CA_W + 1)'(K));
    assign b_oor = ({1'b0, bus.row_addr_b} >= (RB_W + 1)'(K)) |
                   ({1'b0, bus.col_addr_b} >= (CB_W + 1)'(N));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            range_err_reg <= 1'b0;
        end else if (start_accept) begin
            range_err_reg <= 1'b0;
        end else if ((a_rd_en & a_oor) | (b_rd_en & b_oor)) begin
            range_err_reg <= 1'b1;
        end
    end

    assign bus.range_err = range_err_reg;
`else
    assign a_oor         = 1'b0;
    assign b_oor         = 1'b0;
    assign bus.range_err = 1'b0;
`endif

    // Read data holds its last value between served reads; valid marks a fresh word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_a_reg  <= '0;
            data_b_reg  <= '0;
            valid_a_reg <= 1'b0;
            valid_b_reg <= 1'b0;
        end else begin
            valid_a_reg <= a_rd_en;
            valid_b_reg <= b_rd_en;
            if (a_rd_en) begin
                data_a_reg <= a_oor ? '0 : mem_a[a_rd_idx];
            end
            if (b_rd_en) begin
                data_b_reg <= b_oor ? '0 : mem_b[b_rd_idx];
            end
        end
    end

    assign bus.load_ready     = load_ready_int;
    assign bus.load_done      = load_done_reg;
    assign bus.operands_ready = operands_ready_int;
    assign bus.data_in_a      = data_a_reg;
    assign bus.data_in_b      = data_b_reg;
    assign bus.data_valid_a   = valid_a_reg;
    assign bus.data_valid_b   = valid_b_reg;

endmodule

// File: tb/tb_mac_operand_server.sv
// Directed + randomized bench for mac_operand_server against a matrix-level reference model.
module tb_mac_operand_server;
    localparam int M     = 3;
    localparam int K     = 5;
    localparam int N     = 5;
    localparam int DW    = 32;
    localparam int TOTAL = M * K + K * N;
    localparam int RA_W  = $clog2(M);
    localparam int CA_W  = $clog2(K);
    localparam int RB_W  = $clog2(K);
    localparam int CB_W  = $clog2(N);

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mac_operand_server_if #(.M(M), .K(K), .N(N), .DW(DW)) bus ();

    mac_operand_server #(
        .M(M), .K(K), .N(N), .DATA_WIDTH_INIT_MATRIX(DW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Reference model: matrices as 2-D arrays plus the expected read-side outputs.
    logic [DW-1:0] ref_a [M][K];
    logic [DW-1:0] ref_b [K][N];
    logic [DW-1:0] word_buf [TOTAL];
    bit            serve_m;
    logic [DW-1:0] exp_da, exp_db;
    bit            exp_va, exp_vb, exp_rerr;
    int            passed = 0;
    int            total  = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_read_side(input string tag);
        chk({tag, ".data_a"},  bus.data_in_a,      exp_da);
        chk({tag, ".valid_a"}, bus.data_valid_a,   exp_va);
        chk({tag, ".data_b"},  bus.data_in_b,      exp_db);
        chk({tag, ".valid_b"}, bus.data_valid_b,   exp_vb);
        chk({tag, ".opready"}, bus.operands_ready, serve_m);
        chk({tag, ".rerr"},    bus.range_err,      exp_rerr);
    endtask

    // Streams word_buf; gaps inserts an idle cycle after each accept; stop_after>=0 aborts early.
    task automatic load(input string tag, input bit gaps, input int stop_after);
        bus.load_start = 1'b1;
        tick;
        bus.load_start = 1'b0;
        exp_rerr = 1'b0;
        serve_m  = 1'b0;
        chk({tag, ".rerr_clr"}, bus.range_err, exp_rerr);
        for (int i = 0; i < TOTAL; i++) begin
            if (i == stop_after) return;
            bus.load_valid = 1'b1;
            bus.load_data  = word_buf[i];
            chk($sformatf("%s.ready%0d", tag, i), bus.load_ready, 1'b1);
            tick;
            bus.load_valid = 1'b0;
            if (i < TOTAL - 1) begin
                chk($sformatf("%s.nodone%0d", tag, i), bus.load_done, 1'b0);
                if (gaps) begin
                    bus.load_data = $urandom;
                    tick;
                    chk($sformatf("%s.gapready%0d", tag, i), bus.load_ready, 1'b1);
                end
            end
        end
        for (int r = 0; r < M; r++)
            for (int c = 0; c < K; c++) ref_a[r][c] = word_buf[r * K + c];
        for (int r = 0; r < K; r++)
            for (int c = 0; c < N; c++) ref_b[r][c] = word_buf[M * K + r * N + c];
        serve_m = 1'b1;
        chk({tag, ".done"},       bus.load_done,      1'b1);
        chk({tag, ".opready"},    bus.operands_ready, 1'b1);
        chk({tag, ".ready_off"},  bus.load_ready,     1'b0);
        tick;
        chk({tag, ".done_pulse"}, bus.load_done,      1'b0);
        chk({tag, ".opready2"},   bus.operands_ready, 1'b1);
        $display("load %s: %0d words, gaps=%0d", tag, TOTAL, gaps);
    endtask

    task automatic rd(input string tag, input bit rea, input int ra, input int ca,
                      input bit reb, input int rb, input int cb, input bit mac);
        bus.matrix_a_re = rea;
        bus.row_addr_a  = RA_W'(ra);
        bus.col_addr_a  = CA_W'(ca);
        bus.matrix_b_re = reb;
        bus.row_addr_b  = RB_W'(rb);
        bus.col_addr_b  = CB_W'(cb);
        bus.mac_done    = mac;
        tick;
        bus.matrix_a_re = 1'b0;
        bus.matrix_b_re = 1'b0;
        bus.mac_done    = 1'b0;
        exp_va = serve_m && rea;
        exp_vb = serve_m && reb;
        if (exp_va) begin
            if (ra < M && ca < K) exp_da = ref_a[ra][ca];
            else begin exp_da = '0; exp_rerr = 1'b1; end
        end
        if (exp_vb) begin
            if (rb < K && cb < N) exp_db = ref_b[rb][cb];
            else begin exp_db = '0; exp_rerr = 1'b1; end
        end
        if (serve_m && mac) serve_m = 1'b0;
        check_read_side(tag);
        $display("read %s: A(%0d,%0d) re=%0d B(%0d,%0d) re=%0d mac_done=%0d -> a=%0h b=%0h",
                 tag, ra, ca, rea, rb, cb, reb, mac, bus.data_in_a, bus.data_in_b);
    endtask

    task automatic model_reset;
        exp_da = '0; exp_db = '0; exp_va = 1'b0; exp_vb = 1'b0;
        exp_rerr = 1'b0; serve_m = 1'b0;
    endtask

    task automatic fill_directed;
        for (int i = 0; i < M * K; i++) word_buf[i] = DW'(i + 1);
        for (int i = 0; i < K * N; i++) word_buf[M * K + i] = DW'(101 + i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0;
        bus.row_addr_a = '0; bus.col_addr_a = '0; bus.matrix_a_re = 1'b0;
        bus.row_addr_b = '0; bus.col_addr_b = '0; bus.matrix_b_re = 1'b0;
        bus.mac_done = 1'b0;
        resetn = 1'b0;
        model_reset();

        // T1: reset state
        tick; tick;
        chk("t1.load_ready", bus.load_ready, 1'b0);
        chk("t1.load_done",  bus.load_done,  1'b0);
        check_read_side("t1");
        resetn = 1'b1;
        tick;
        chk("t1.rel.load_ready", bus.load_ready,     1'b0);
        chk("t1.rel.opready",    bus.operands_ready, 1'b0);
        bus.load_valid = 1'b1; bus.load_data = 32'hdead;
        tick;
        bus.load_valid = 1'b0;
        chk("t1.idle_valid.ready", bus.load_ready, 1'b0);
        $display("t1 reset checks done");

        // T2: back-to-back load
        fill_directed();
        load("t2", 1'b0, -1);

        // T3: reads
        rd("t3.ab", 1'b1, 2, 4, 1'b1, 4, 4, 1'b0);
        chk("t3.a15",  bus.data_in_a, 15);
        chk("t3.b125", bus.data_in_b, 125);
        rd("t3.a01", 1'b1, 0, 1, 1'b0, 0, 0, 1'b0);
        chk("t3.a2",   bus.data_in_a, 2);
        chk("t3.bhold", bus.data_in_b, 125);
        bus.load_start = 1'b1;
        tick;
        bus.load_start = 1'b0;
        chk("t3.start_ignored.opready", bus.operands_ready, 1'b1);
        chk("t3.start_ignored.ready",   bus.load_ready,     1'b0);

        // T4: gapped reload, then stray load_valid in SERVE
        rd("t4.release", 1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        load("t4", 1'b1, -1);
        rd("t4.rd", 1'b1, 1, 2, 1'b1, 3, 0, 1'b0);
        chk("t4.a8",   bus.data_in_a, 8);
        chk("t4.b116", bus.data_in_b, 116);
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1; bus.load_data = $urandom;
            tick;
            chk("t4.serve_valid.ready", bus.load_ready, 1'b0);
            chk("t4.serve_valid.done",  bus.load_done,  1'b0);
        end
        bus.load_valid = 1'b0;
        rd("t4.rd2", 1'b1, 1, 2, 1'b1, 3, 0, 1'b0);

        // T5: mac_done with a concurrent read
        rd("t5.mac", 1'b1, 1, 0, 1'b0, 0, 0, 1'b1);
        chk("t5.a6", bus.data_in_a, 6);
        rd("t5.late", 1'b1, 2, 2, 1'b1, 1, 1, 1'b0);

        // T6: reset in LOAD_B after 20 accepts
        load("t6.partial", 1'b0, 20);
        resetn = 1'b0;
        model_reset();
        #1;
        chk("t6.rst.ready", bus.load_ready, 1'b0);
        check_read_side("t6.rst");
        tick;
        resetn = 1'b1;
        tick;
        chk("t6.idle.ready", bus.load_ready, 1'b0);
        load("t6.reload", 1'b0, -1);
        rd("t6.ab", 1'b1, 2, 4, 1'b1, 4, 4, 1'b0);
        chk("t6.a15",  bus.data_in_a, 15);
        chk("t6.b125", bus.data_in_b, 125);
        rd("t6.release", 1'b0, 0, 0, 1'b0, 0, 0, 1'b1);

        // Random contents and random in-range read traffic
        for (int i = 0; i < TOTAL; i++) word_buf[i] = $urandom;
        load("rnd", 1'b0, -1);
        for (int i = 0; i < 40; i++) begin
            rd($sformatf("rnd%0d", i),
               1'($urandom_range(1)), int'($urandom_range(M - 1)), int'($urandom_range(K - 1)),
               1'($urandom_range(1)), int'($urandom_range(K - 1)), int'($urandom_range(N - 1)),
               1'b0);
        end
        rd("rnd.release", 1'b1, 0, 0, 1'b1, K - 1, N - 1, 1'b1);

`ifdef OPERAND_RANGE_CHECK_EN
        // T7: out-of-range reads
        load("t7", 1'b0, -1);
        rd("t7.a30", 1'b1, 3, 0, 1'b0, 0, 0, 1'b0);
        chk("t7.a_zero", bus.data_in_a, 0);
        chk("t7.rerr",   bus.range_err, 1'b1);
        rd("t7.b05", 1'b0, 0, 0, 1'b1, 0, 5, 1'b0);
        rd("t7.sticky", 1'b1, 1, 1, 1'b1, 1, 1, 1'b0);
        rd("t7.release", 1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        chk("t7.rerr_idle", bus.range_err, 1'b1);
        load("t7.clear", 1'b0, -1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
